// File: rtl/bram_tree_arbiter.sv
// Round-robin arbiter and sequencer for the BRAM tree priority queue: grants one
// replace request, pulses the tree, waits out the re-heapify window, returns the old top.
module bram_tree_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_WIDTH     = 16,
    localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW           = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_item,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_item,
    output logic                          pq_replace,
    output logic [DATA_WIDTH-1:0]         pq_new_item,
    input  logic [DATA_WIDTH-1:0]         pq_top_item,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic [CNT_WIDTH-1:0]          op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_e;

    state_e                state_q,       state_d;
    logic [GW-1:0]         grant_id_q,    grant_id_d;
    logic [DATA_WIDTH-1:0] pq_new_item_q, pq_new_item_d;
    logic [DATA_WIDTH-1:0] resp_item_q,   resp_item_d;
    logic [NUM_REQ-1:0]    resp_valid_q,  resp_valid_d;
    logic                  pq_replace_q,  pq_replace_d;
    logic                  busy_q,        busy_d;
    logic [CNT_WIDTH-1:0]  op_count_q,    op_count_d;
    logic [SW-1:0]         settle_cnt_q,  settle_cnt_d;

    logic                  hi_found, lo_found, sel_found;
    logic [GW-1:0]         hi_idx, lo_idx, sel_idx;
    logic                  accept;

    // Rotating priority: first valid above the last winner, else the lowest valid overall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hi_found && req_valid[i] && (GW'(i) > grant_id_q)) begin
                hi_found = 1'b1;
                hi_idx   = GW'(i);
            end
            if (!lo_found && req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = GW'(i);
            end
        end
        sel_found = hi_found | lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && sel_found) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign accept = |(req_ready & req_valid);

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        pq_new_item_d = pq_new_item_q;
        resp_item_d   = resp_item_q;
        resp_valid_d  = '0;
        pq_replace_d  = 1'b0;
        op_count_d    = op_count_q;
        settle_cnt_d  = settle_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_id_d    = sel_idx;
                    pq_new_item_d = req_item[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                    resp_item_d   = pq_top_item;
                    pq_replace_d  = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                settle_cnt_d = SW'(SETTLE_CYCLES - 1);
                state_d      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    resp_valid_d[grant_id_q] = 1'b1;
                    state_d                  = RESP;
                end else begin
                    settle_cnt_d = settle_cnt_q - SW'(1);
                end
            end
            RESP: begin
                op_count_d = op_count_q + CNT_WIDTH'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_id_q    <= GW'(NUM_REQ - 1);
            pq_new_item_q <= '0;
            resp_item_q   <= '0;
            resp_valid_q  <= '0;
            pq_replace_q  <= 1'b0;
            busy_q        <= 1'b0;
            op_count_q    <= '0;
            settle_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            pq_new_item_q <= pq_new_item_d;
            resp_item_q   <= resp_item_d;
            resp_valid_q  <= resp_valid_d;
            pq_replace_q  <= pq_replace_d;
            busy_q        <= busy_d;
            op_count_q    <= op_count_d;
            settle_cnt_q  <= settle_cnt_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_item   = resp_item_q;
    assign pq_replace  = pq_replace_q;
    assign pq_new_item = pq_new_item_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_bram_tree_arbiter.sv
// Directed bench for bram_tree_arbiter: handshake timing, rotation, busy hold-off,
// mid-operation reset and op_count wrap with a 4-bit counter.
module tb_bram_tree_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int ST = 64;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_item;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_item;
    logic              pq_replace;
    logic [DW-1:0]     pq_new_item;
    logic [DW-1:0]     pq_top_item;
    logic              busy;
    logic [1:0]        grant_id;
    logic [CW-1:0]     op_count;

    int n_checks = 0;
    int n_errors = 0;
    logic multihot = 1'b0;

    bram_tree_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(ST), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_item(req_item), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_item(resp_item),
        .pq_replace(pq_replace), .pq_new_item(pq_new_item), .pq_top_item(pq_top_item),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(req_ready) > 1) multihot = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until req_ready goes nonzero, continuing from start.
    task automatic wait_ready(input int start, output int n, output logic [NR-1:0] rdy);
        n = start;
        #1;
        while (req_ready == '0 && n < 400) begin
            tick();
            n++;
        end
        rdy = req_ready;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (resp_valid == '0 && n < 400);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_op(input int idx, input logic [31:0] item, input logic [31:0] top);
        int n;
        logic [NR-1:0] rdy;
        req_valid = NR'(1) << idx;
        req_item[idx*DW +: DW] = item;
        pq_top_item = top;
        wait_ready(0, n, rdy);
        check("op_ready", 32'(rdy), 32'(NR'(1) << idx));
        tick();
        req_valid = '0;
        wait_resp(n);
        check("op_resp_item", resp_item, top);
        tick();
    endtask

    initial begin
        int n, m;
        logic [NR-1:0] rdy;
        logic bad_ready, stale, saw_resp;

        rst = 1'b1;
        req_valid = '0;
        req_item = '0;
        pq_top_item = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 3);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_pq_replace", 32'(pq_replace), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_item", resp_item, 0);
        check("rst_pq_new_item", pq_new_item, 0);
        rst = 1'b0;
        tick();

        // Single transaction timing
        req_valid = 4'b0001;
        req_item[0 +: DW] = 32'h10;
        pq_top_item = 32'h55;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        pq_top_item = 32'h66;
        check("t1_replace_hi", 32'(pq_replace), 1);
        check("t1_new_item", pq_new_item, 32'h10);
        check("t1_busy", 32'(busy), 1);
        check("t1_grant", 32'(grant_id), 0);
        tick();
        check("t1_replace_lo", 32'(pq_replace), 0);
        wait_resp(m);
        check("t1_latency", 32'(2 + m), ST + 2);
        check("t1_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_item", resp_item, 32'h55);
        tick();
        check("t1_op_count", 32'(op_count), 1);
        check("t1_resp_clear", 32'(resp_valid), 0);
        check("t1_idle", 32'(busy), 0);
        check("t1_resp_hold", resp_item, 32'h55);

        // Round robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < NR; i++) req_item[i*DW +: DW] = 32'hA0 + 32'(i);
        req_valid = 4'b1111;
        n = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ready(n == 0 ? 0 : 1, n, rdy);
            if (g > 0) check("rr_spacing", 32'(n), ST + 3);
            check("rr_ready", 32'(rdy), 32'(4'b0001 << (g % NR)));
            pq_top_item = 32'hC0 + 32'(g);
            tick();
            check("rr_grant", 32'(grant_id), 32'(g % NR));
            check("rr_new_item", pq_new_item, 32'hA0 + 32'(g % NR));
            n = 1;
        end
        req_valid = '0;
        check("rr_onehot", 32'(multihot), 0);

        // Request arriving while busy waits, pq_new_item held
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
        end
        req_valid = 4'b0100;
        req_item[2*DW +: DW] = 32'hB2;
        bad_ready = 1'b0;
        stale = 1'b0;
        #1;
        while (busy && n < 400) begin
            if (req_ready != '0) bad_ready = 1'b1;
            if (pq_new_item != 32'hA0) stale = 1'b1;
            tick();
            n++;
        end
        wait_ready(n, n, rdy);
        check("busy_no_ready", 32'(bad_ready), 0);
        check("busy_item_held", 32'(stale), 0);
        check("busy_ready", 32'(rdy), 32'h4);
        check("busy_spacing", 32'(n), ST + 3);
        tick();
        req_valid = '0;
        check("busy_new_item", pq_new_item, 32'hB2);
        check("busy_grant", 32'(grant_id), 2);

        // Reset in the middle of SETTLE (counter at 30)
        for (int i = 0; i < 34; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_grant", 32'(grant_id), 3);
        check("mid_rst_resp", 32'(resp_valid), 0);
        saw_resp = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (resp_valid != '0) saw_resp = 1'b1;
            tick();
        end
        check("mid_rst_no_resp", 32'(saw_resp), 0);
        req_valid = 4'b1001;
        req_item[3*DW +: DW] = 32'hD3;
        req_item[0 +: DW] = 32'hD0;
        pq_top_item = 32'h77;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("post_rst_grant", 32'(grant_id), 0);
        check("post_rst_item", pq_new_item, 32'hD0);
        wait_resp(m);
        check("post_rst_latency", 32'(1 + m), ST + 2);
        check("post_rst_resp_valid", 32'(resp_valid), 32'h1);
        check("post_rst_resp_item", resp_item, 32'h77);
        tick();
        check("post_rst_op_count", 32'(op_count), 1);

        // op_count wrap with a 4-bit counter
        for (int k = 0; k < 14; k++) do_op(k % NR, 32'h300 + 32'(k), 32'h400 + 32'(k));
        check("wrap_at_max", 32'(op_count), 15);
        do_op(1, 32'h3FF, 32'h4FF);
        check("wrap_to_zero", 32'(op_count), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
